// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: streams sequential IM reads, tags each word with its PC, and buffers DEPTH entries.
// Optional macro PREFETCH_BYPASS_EN presents a returning word directly when the queue is empty.
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        IM_enable,
    output logic [31:0] IM_address,
    input  logic [31:0] IM_out
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   pending_pc;
    logic          pending;
    logic          kill;
    logic [31:0]   fifo_inst [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic [AW+1:0] credit;

    logic issue;
    logic resp_valid;
    logic bypass_hit;
    logic pop;
    logic fifo_pop;
    logic push;
    logic unused_rpc_bits;

    assign unused_rpc_bits = ^redirect_pc[1:0];

    // Credit check counts the in-flight read so a returning word always has a free slot.
    assign credit     = {1'b0, count} + {{(AW + 1){1'b0}}, pending};
    assign issue      = rst && !redirect && (credit < (AW + 2)'(DEPTH));
    assign IM_enable  = issue;
    assign IM_address = fetch_pc;
    assign resp_valid = pending && !kill;

`ifdef PREFETCH_BYPASS_EN
    assign bypass_hit = resp_valid && (count == '0);
`else
    assign bypass_hit = 1'b0;
`endif

    assign inst_valid = (count != '0) || bypass_hit;
    assign pop        = inst_valid && inst_ready && !redirect;
    assign fifo_pop   = pop && (count != '0);
    assign push       = resp_valid && !redirect && !(bypass_hit && inst_ready);

    always_comb begin
        inst_out = 32'h0;
        inst_pc  = 32'h0;
        if (count != '0) begin
            inst_out = fifo_inst[head];
            inst_pc  = fifo_pc[head];
        end else if (bypass_hit) begin
            inst_out = IM_out;
            inst_pc  = pending_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc   <= RESET_PC;
            pending_pc <= 32'h0;
            pending    <= 1'b0;
            kill       <= 1'b0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            pending  <= 1'b0;
            kill     <= pending;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (fifo_pop) begin
                head <= head + 1'b1;
            end
            if (push && !fifo_pop) begin
                count <= count + 1'b1;
            end else if (!push && fifo_pop) begin
                count <= count - 1'b1;
            end
            pending <= issue;
            kill    <= 1'b0;
            if (issue) begin
                pending_pc <= fetch_pc;
                fetch_pc   <= fetch_pc + 32'd4;
            end
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[tail] <= IM_out;
            fifo_pc[tail]   <= pending_pc;
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: directed scenarios plus random redirect/backpressure against a queue-level model.
module tb_if_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PREFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        IM_enable;
    logic [31:0] IM_address;
    logic [31:0] im_out;

    int n_checks;
    int n_pass;
    int en_pulses;
    bit obs_valid;
    logic [31:0] obs_pc;

    logic [31:0] m_q [$];
    logic [31:0] m_fetch_pc;
    bit          m_inflight;
    logic [31:0] m_pend_pc;

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_ready  (inst_ready),
        .inst_valid  (inst_valid),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc),
        .IM_enable   (IM_enable),
        .IM_address  (IM_address),
        .IM_out      (im_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] im_word(input logic [31:0] a);
        return 32'h1000_0000 + {16'h0, a[17:2]};
    endfunction

    always @(posedge clk) begin
        if (IM_enable) im_out <= im_word(IM_address);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fetch_pc = RESET_PC;
        m_inflight = 1'b0;
        m_pend_pc  = 32'h0;
    endtask

    // One cycle: drive inputs, compare against the model, then advance the model.
    task automatic step(input bit rd, input logic [31:0] rpc, input bit rdy);
        bit          exp_en;
        bit          exp_valid;
        bit          byp;
        bit          consumed;
        logic [31:0] exp_pc;
        @(negedge clk);
        redirect    = rd;
        redirect_pc = rpc;
        inst_ready  = rdy;
        #1;
        exp_en    = !rd && (m_q.size() + int'(m_inflight) < DEPTH);
        exp_valid = 1'b0;
        byp       = 1'b0;
        exp_pc    = 32'h0;
        if (m_q.size() != 0) begin
            exp_valid = 1'b1;
            exp_pc    = m_q[0];
        end
`ifdef PREFETCH_BYPASS_EN
        else if (m_inflight) begin
            exp_valid = 1'b1;
            exp_pc    = m_pend_pc;
            byp       = 1'b1;
        end
`endif
        check_eq("im_enable", {31'b0, IM_enable}, {31'b0, exp_en});
        check_eq("im_address", IM_address, m_fetch_pc);
        check_eq("inst_valid", {31'b0, inst_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            check_eq("inst_pc", inst_pc, exp_pc);
            check_eq("inst_out", inst_out, im_word(exp_pc));
        end
        obs_valid = inst_valid;
        obs_pc    = inst_pc;
        if (IM_enable) en_pulses++;

        if (rd) begin
            m_q.delete();
            m_inflight = 1'b0;
            m_fetch_pc = {rpc[31:2], 2'b00};
        end else begin
            consumed = 1'b0;
            if (exp_valid && rdy) begin
                if (byp) consumed = 1'b1;
                else void'(m_q.pop_front());
            end
            if (m_inflight && !consumed) m_q.push_back(m_pend_pc);
            if (exp_en) begin
                m_inflight = 1'b1;
                m_pend_pc  = m_fetch_pc;
                m_fetch_pc = m_fetch_pc + 32'd4;
            end else begin
                m_inflight = 1'b0;
            end
        end
        @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_im_enable"}, {31'b0, IM_enable}, 32'h0);
        check_eq({tag, "_im_address"}, IM_address, RESET_PC);
        check_eq({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'h0);
        check_eq({tag, "_inst_out"}, inst_out, 32'h0);
        check_eq({tag, "_inst_pc"}, inst_pc, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        en_pulses   = 0;
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #2 rst = 1'b1;

        // Streaming from reset with no backpressure.
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 32'h0, 1'b1);
            if (i == LAT - 1) check_eq("first_lat_low", {31'b0, obs_valid}, 32'h0);
            if (i >= LAT) begin
                check_eq("stream_valid", {31'b0, obs_valid}, 32'h1);
                check_eq("stream_pc", obs_pc, RESET_PC + 32'(4 * (i - LAT)));
            end
        end

        // Backpressure: exactly DEPTH reads, then in-order drain.
        step(1'b1, 32'h0, 1'b0);
        en_pulses = 0;
        repeat (10) step(1'b0, 32'h0, 1'b0);
        check_eq("bp_pulses", 32'(en_pulses), 32'd4);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 32'h0, 1'b1);
            check_eq("bp_drain_pc", obs_pc, 32'(4 * k));
        end

        // Redirect with count=3 and a read in flight.
        step(1'b1, 32'h0, 1'b0);
        repeat (4) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0100, 1'b0);
        for (int k = 1; k <= LAT + 1; k++) begin
            step(1'b0, 32'h0, 1'b1);
            if (k == LAT) check_eq("redir_early", {31'b0, obs_valid}, 32'h0);
            if (k == LAT + 1) begin
                check_eq("redir_valid", {31'b0, obs_valid}, 32'h1);
                check_eq("redir_pc", obs_pc, 32'h0000_0100);
            end
        end

        // Redirect to an unaligned PC with a simultaneous pop, then back-to-back redirects.
        repeat (3) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_0103, 1'b1);
        for (int k = 1; k <= LAT + 1; k++) step(1'b0, 32'h0, 1'b1);
        check_eq("unaligned_pc", obs_pc, 32'h0000_0100);
        repeat (2) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_0200, 1'b1);
        step(1'b1, 32'h0000_0300, 1'b1);
        for (int k = 1; k <= LAT + 1; k++) step(1'b0, 32'h0, 1'b1);
        check_eq("b2b_pc", obs_pc, 32'h0000_0300);
        repeat (4) step(1'b0, 32'h0, 1'b1);

        // Address wrap past 32'hFFFF_FFFC.
        step(1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int k = 1; k <= LAT; k++) step(1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 32'h0, 1'b1);
            check_eq("wrap_pc", obs_pc, 32'hFFFF_FFF8 + 32'(4 * k));
        end

        // Asynchronous reset with count=2 and a read pending.
        step(1'b1, 32'h0000_0040, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        for (int i = 0; i <= LAT; i++) step(1'b0, 32'h0, 1'b1);
        check_eq("post_rst_pc", obs_pc, RESET_PC);

        // Random redirects and backpressure.
        for (int i = 0; i < 400; i++) begin
            bit          rd;
            bit          rdy;
            logic [31:0] rpc;
            rd  = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
            else rpc = $urandom;
            step(rd, rpc, rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
